uart_rx_sb_ctrl: RTL and testbench

UART_RX_SB_CTRL -- requirements
Module: uart_rx_sb_ctrl

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx.sv | 129 ++++++++++++
 rtl/uart_rx_sb_ctrl.sv | 135 +++++++++++++
 tb/tb_uart_rx_sb_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: register offsets, FSM states and status bits.
// Parity support (PARITY state, status bit 2) exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam logic [31:0] REG_DATA   = 32'h0000_0000;
   localparam logic [31:0] REG_VALID  = 32'h0000_0004;
   localparam logic [31:0] REG_BUSY   = 32'h0000_0008;
   localparam logic [31:0] REG_DIV    = 32'h0000_000C;
   localparam logic [31:0] REG_STATUS = 32'h0000_0010;
   localparam logic [31:0] REG_PARITY = 32'h0000_0014;
   localparam logic [31:0] REG_SRST   = 32'h0000_0024;

   localparam int STAT_FRAME   = 0;
   localparam int STAT_OVERRUN = 1;
   localparam int STAT_PARITY  = 2;

   // Smallest divisor that still leaves a meaningful mid-bit sample point.
   localparam logic [15:0] DIV_MIN = 16'd16;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef UART_RX_PARITY_EN
      RX_PARITY,
`endif
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART receive engine: 2-flop line synchronizer, bit-period counter and frame FSM (8N1, LSB first).
// With UART_RX_PARITY_EN defined, an even-parity bit is expected when parity_en is set.
module uart_rx
   import uart_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        rx,
   input  logic [15:0] div,
`ifdef UART_RX_PARITY_EN
   input  logic        parity_en,
   output logic        parity_err,
`endif
   output logic [7:0]  data_byte,
   output logic        done,
   output logic        frame_err,
   output logic        busy
);

   logic        rx_meta, rx_sync, rx_last;
   logic        fall, mid, last;
   logic [15:0] div_act, cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   rx_state_t   state, state_next;
`ifdef UART_RX_PARITY_EN
   logic        par_bad;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_last <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_last <= rx_sync;
      end
   end

   assign fall = rx_last & ~rx_sync;
   assign mid  = (cnt == {1'b0, div_act[15:1]});
   assign last = (cnt == div_act - 16'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RX_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = RX_IDLE;
      end else begin
         case (state)
            RX_IDLE:      if (fall) state_next = RX_START;
            RX_START: begin
               if (mid && rx_sync) state_next = RX_IDLE;
               else if (last)      state_next = RX_DATA;
            end
            RX_DATA: begin
               if (last && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_next = parity_en ? RX_PARITY : RX_STOP;
`else
                  state_next = RX_STOP;
`endif
               end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY:    if (last) state_next = RX_STOP;
`endif
            RX_STOP:      if (mid) state_next = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_sync) state_next = RX_IDLE;
            default:      state_next = RX_IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = (state != RX_IDLE);
      done      = 1'b0;
      frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err = 1'b0;
`endif
      if (state == RX_STOP && mid && !clear) begin
         if (!rx_sync)     frame_err  = 1'b1;
`ifdef UART_RX_PARITY_EN
         else if (par_bad) parity_err = 1'b1;
`endif
         else              done       = 1'b1;
      end
   end

   // The divisor is latched while idle so a mid-frame change waits for the next start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         bit_idx <= '0;
         div_act <= DIV_MIN;
      end else if (state == RX_IDLE || clear) begin
         cnt     <= '0;
         bit_idx <= '0;
         div_act <= div;
      end else begin
         cnt <= last ? '0 : cnt + 16'd1;
         if (state == RX_DATA && last) bit_idx <= bit_idx + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (state == RX_DATA && mid) shreg <= {rx_sync, shreg[7:1]};
   end

   assign data_byte = shreg;

`ifdef UART_RX_PARITY_EN
   // Even parity: the parity bit must equal the XOR of the data bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              par_bad <= 1'b0;
      else if (state == RX_IDLE)            par_bad <= 1'b0;
      else if (state == RX_PARITY && mid)   par_bad <= rx_sync ^ (^shreg);
   end
`endif

endmodule

// File: rtl/uart_rx_sb_ctrl.sv
// Bus-mapped UART receiver: register file, interrupt and soft reset around uart_rx.
// Define UART_RX_PARITY_EN to add the parity_en register and the parity error status bit.
module uart_rx_sb_ctrl
   import uart_pkg::*;
#(
   parameter int BIT_CYCLES_RST = 86
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        write_enable_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] write_data_i,
   output logic [31:0] read_data_o,
   output logic        interrupt_request_o,
   input  logic        interrupt_return_i,
   input  logic        rx_i
);

   localparam logic [15:0] DIV_RST = 16'(BIT_CYCLES_RST);

   logic        rd, wr, soft_rst, rd_data, rd_status;
   logic [7:0]  data_q;
   logic        valid_q, overrun_q, frame_err_q, irq_q;
   logic [15:0] div_q;
   logic [2:0]  status;
   logic [31:0] rd_mux;
   logic [7:0]  rx_byte;
   logic        rx_done, rx_frame_err, rx_busy;
   logic        unused_wdata;
`ifdef UART_RX_PARITY_EN
   logic        parity_en_q, parity_err_q, rx_parity_err;
`endif

   assign rd        = req_i & ~write_enable_i;
   assign wr        = req_i & write_enable_i;
   assign soft_rst  = wr && (addr_i == REG_SRST) && write_data_i[0];
   assign rd_data   = rd && (addr_i == REG_DATA);
   assign rd_status = rd && (addr_i == REG_STATUS);

   assign unused_wdata = ^write_data_i[31:16];

   uart_rx u_rx (
      .clk        (clk_i),
      .rst        (rst_i),
      .clear      (soft_rst),
      .rx         (rx_i),
      .div        (div_q),
`ifdef UART_RX_PARITY_EN
      .parity_en  (parity_en_q),
      .parity_err (rx_parity_err),
`endif
      .data_byte  (rx_byte),
      .done       (rx_done),
      .frame_err  (rx_frame_err),
      .busy       (rx_busy)
   );

   // A completion in the same cycle as a clearing read or mret keeps the flag set.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i || soft_rst) begin
         data_q      <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         irq_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         if (rx_done) data_q <= rx_byte;

         if (rx_done)      valid_q <= 1'b1;
         else if (rd_data) valid_q <= 1'b0;

         if (rx_done && valid_q) overrun_q <= 1'b1;
         else if (rd_status)     overrun_q <= 1'b0;

         if (rx_frame_err)   frame_err_q <= 1'b1;
         else if (rd_status) frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         if (rx_parity_err)  parity_err_q <= 1'b1;
         else if (rd_status) parity_err_q <= 1'b0;
`endif
         if (rx_done)                 irq_q <= 1'b1;
         else if (interrupt_return_i) irq_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q <= DIV_RST;
`ifdef UART_RX_PARITY_EN
         parity_en_q <= 1'b0;
`endif
      end else if (wr) begin
         if (addr_i == REG_DIV && write_data_i[15:0] >= DIV_MIN) div_q <= write_data_i[15:0];
`ifdef UART_RX_PARITY_EN
         if (addr_i == REG_PARITY) parity_en_q <= write_data_i[0];
`endif
      end
   end

   always_comb begin
      status               = '0;
      status[STAT_FRAME]   = frame_err_q;
      status[STAT_OVERRUN] = overrun_q;
`ifdef UART_RX_PARITY_EN
      status[STAT_PARITY]  = parity_err_q;
`endif
   end

   always_comb begin
      rd_mux = '0;
      case (addr_i)
         REG_DATA:   rd_mux = {24'd0, data_q};
         REG_VALID:  rd_mux = {31'd0, valid_q};
         REG_BUSY:   rd_mux = {31'd0, rx_busy};
         REG_DIV:    rd_mux = {16'd0, div_q};
         REG_STATUS: rd_mux = {29'd0, status};
`ifdef UART_RX_PARITY_EN
         REG_PARITY: rd_mux = {31'd0, parity_en_q};
`endif
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)   read_data_o <= '0;
      else if (rd) read_data_o <= rd_mux;
   end

   assign interrupt_request_o = irq_q;

endmodule

// File: tb/tb_uart_rx_sb_ctrl.sv
// Directed bench for uart_rx_sb_ctrl (default build); expectations queue up and a monitor checks them.
module tb_uart_rx_sb_ctrl;

   localparam int DIV = 86;
   // Done is registered: 2 synchronizer cycles, 1 edge-to-START cycle, 9 full bits, half the stop bit.
   localparam int RET_AT = 3 + 9 * DIV + DIV / 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        irq;
   logic        ret = 1'b0;
   logic        rx = 1'b1;

   typedef struct { logic [31:0] exp; string name; } rd_exp_t;
   typedef struct { int sel; logic [31:0] exp; string name; } probe_t;

   rd_exp_t rd_q[$];
   probe_t  pr_q[$];
   rd_exp_t cur_rd;
   probe_t  cur_pr;
   logic [31:0] act;
   logic    rd_pend = 1'b0;
   int      total = 0;
   int      bad = 0;

   uart_rx_sb_ctrl #(.BIT_CYCLES_RST(DIV)) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .req_i               (req),
      .write_enable_i      (we),
      .addr_i              (addr),
      .write_data_i        (wdata),
      .read_data_o         (rdata),
      .interrupt_request_o (irq),
      .interrupt_return_i  (ret),
      .rx_i                (rx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_pend <= req && !we;

   // Monitor: read data is compared the half-cycle after the read is taken.
   always @(negedge clk) begin
      if (rd_pend) begin
         total++;
         if (rd_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_read got=0x%08h", rdata);
         end else begin
            cur_rd = rd_q.pop_front();
            if (rdata !== cur_rd.exp) begin
               bad++;
               $display("FAIL %s got=0x%08h want=0x%08h", cur_rd.name, rdata, cur_rd.exp);
            end
         end
      end
      while (pr_q.size() > 0) begin
         cur_pr = pr_q.pop_front();
         act = (cur_pr.sel == 0) ? {31'd0, irq} : rdata;
         total++;
         if (act !== cur_pr.exp) begin
            bad++;
            $display("FAIL %s got=0x%08h want=0x%08h", cur_pr.name, act, cur_pr.exp);
         end
      end
   end

   task automatic bus_rd(input logic [31:0] a, input logic [31:0] e, input string n);
      rd_q.push_back('{e, n});
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
   endtask

   task automatic probe(input int sel, input logic [31:0] e, input string n);
      @(posedge clk);
      #1;
      pr_q.push_back('{sel, e, n});
      @(negedge clk);
   endtask

   task automatic irq_return();
      @(negedge clk);
      ret = 1'b1;
      @(negedge clk);
      ret = 1'b0;
   endtask

   // Drives start, 8 data bits LSB first and the stop bit; ret pulses on cycle ret_at if >= 0.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int ret_at, input int nbits);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int j = 0; j < nbits * DIV; j++) begin
         @(negedge clk);
         rx = bits[j / DIV];
         ret = (j == ret_at);
      end
      @(negedge clk);
      rx = 1'b1;
      ret = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (5) @(negedge clk);
      rst = 1'b0;

      probe(1, 32'h0, "rst_read_data");
      probe(0, 32'h0, "rst_irq");
      bus_rd(32'h00, 32'h0, "rst_data");
      bus_rd(32'h04, 32'h0, "rst_valid");
      bus_rd(32'h08, 32'h0, "rst_busy");
      bus_rd(32'h0C, DIV, "rst_div");
      bus_rd(32'h10, 32'h0, "rst_status");
      bus_rd(32'h14, 32'h0, "rst_parity_en");

      send_frame(8'hA5, 1'b1, -1, 10);
      probe(0, 32'h1, "a5_irq");
      bus_rd(32'h04, 32'h1, "a5_valid");
      bus_rd(32'h00, 32'hA5, "a5_data");
      bus_rd(32'h04, 32'h0, "a5_valid_cleared");
      probe(0, 32'h1, "a5_irq_held");
      irq_return();
      probe(0, 32'h0, "a5_irq_returned");

      @(negedge clk); rx = 1'b0;
      repeat (20) @(negedge clk);
      rx = 1'b1;
      repeat (200) @(negedge clk);
      bus_rd(32'h04, 32'h0, "glitch_valid");
      bus_rd(32'h08, 32'h0, "glitch_busy");
      bus_rd(32'h10, 32'h0, "glitch_status");
      probe(0, 32'h0, "glitch_irq");

      send_frame(8'h3C, 1'b0, -1, 10);
      repeat (5) @(negedge clk);
      bus_rd(32'h08, 32'h0, "ferr_busy");
      bus_rd(32'h04, 32'h0, "ferr_valid");
      probe(0, 32'h0, "ferr_irq");
      bus_rd(32'h10, 32'h1, "ferr_status");
      bus_rd(32'h10, 32'h0, "ferr_status_cleared");

      send_frame(8'h11, 1'b1, -1, 10);
      send_frame(8'h22, 1'b1, -1, 10);
      bus_rd(32'h10, 32'h2, "ovr_status");
      bus_rd(32'h04, 32'h1, "ovr_valid");
      bus_rd(32'h00, 32'h22, "ovr_data");
      bus_rd(32'h04, 32'h0, "ovr_valid_cleared");
      bus_rd(32'h10, 32'h0, "ovr_status_cleared");
      irq_return();
      probe(0, 32'h0, "ovr_irq_returned");

      send_frame(8'h96, 1'b1, RET_AT, 10);
      probe(0, 32'h1, "coinc_irq_stays");
      bus_rd(32'h00, 32'h96, "coinc_data");
      irq_return();
      probe(0, 32'h0, "coinc_irq_returned");

      bus_rd(32'h0C, DIV, "pre_rst_div");
      send_frame(8'h5A, 1'b1, -1, 4);
      @(negedge clk);
      rx = 1'b0;
      repeat (DIV / 2) @(negedge clk);
      rst = 1'b1;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      probe(1, 32'h0, "hrst_read_data");
      probe(0, 32'h0, "hrst_irq");
      bus_rd(32'h00, 32'h0, "hrst_data");
      bus_rd(32'h04, 32'h0, "hrst_valid");
      bus_rd(32'h08, 32'h0, "hrst_busy");
      bus_rd(32'h10, 32'h0, "hrst_status");
      repeat (2 * DIV) @(negedge clk);
      bus_rd(32'h04, 32'h0, "hrst_no_partial");
      send_frame(8'h77, 1'b1, -1, 10);
      bus_rd(32'h04, 32'h1, "post_rst_valid");
      bus_rd(32'h00, 32'h77, "post_rst_data");
      irq_return();

      send_frame(8'h5C, 1'b1, -1, 10);
      bus_wr(32'h0C, 32'd50);
      bus_wr(32'h24, 32'h1);
      bus_rd(32'h04, 32'h0, "srst_valid");
      bus_rd(32'h00, 32'h0, "srst_data");
      bus_rd(32'h10, 32'h0, "srst_status");
      bus_rd(32'h0C, 32'd50, "srst_div_kept");
      probe(0, 32'h0, "srst_irq");

      bus_wr(32'h0C, 32'd15);
      bus_rd(32'h0C, 32'd50, "div_below_min_ignored");
      bus_wr(32'h0C, 32'd16);
      bus_rd(32'h0C, 32'd16, "div_min_accepted");
      bus_wr(32'h0C, DIV);
      bus_wr(32'h14, 32'h1);
      bus_rd(32'h14, 32'h0, "parity_en_absent");
      bus_wr(32'h00, 32'hFF);
      bus_rd(32'h00, 32'h0, "ro_write_ignored");
      bus_rd(32'h18, 32'h0, "unmapped_read");
      bus_rd(32'h24, 32'h0, "srst_reads_zero");

      repeat (10) @(negedge clk);
      if (rd_q.size() != 0 || pr_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL leftover_expectations got=%0d want=0", rd_q.size() + pr_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
